// File: rtl/ahb_ap_ctrl.sv
// AHB-Lite access-port controller: pops debug commands and runs them
// as single non-overlapped AHB transfers, pushing read data to the rsp FIFO.
module ahb_ap_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  cmd_empty,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [1:0]            cmd_size,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  output logic                  cmd_rinc,
  input  logic                  rsp_wfull,
  output logic                  rsp_winc,
  output logic [DATA_WIDTH-1:0] rsp_wdata,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic                  HWRITE,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_ADDR,
    S_DATA,
    S_PUSH
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  C_ONE = CNT_WIDTH'(1);

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            size_q, size_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  rinc_q, rinc_d;
  logic                  err_q, err_d;

  logic [1:0]            csize;
  logic [ADDR_WIDTH-1:0] caddr;
  logic [ADDR_WIDTH-1:0] step;

  // Size 3 behaves as word; start address is forced to alignment.
  always_comb begin
    csize = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
    caddr = cmd_addr;
    if (csize == 2'd1) caddr[0] = 1'b0;
    if (csize == 2'd2) caddr[1:0] = 2'b00;
  end

  assign step = A_ONE << size_q;

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    rinc_d  = 1'b0;
    err_d   = err_q;
    if (err_clr) err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!cmd_empty) begin
          rinc_d  = 1'b1;
          write_d = cmd_write;
          addr_d  = caddr;
          wdata_d = cmd_wdata;
          size_d  = csize;
          cnt_d   = cmd_count;
          state_d = cmd_write ? S_ADDR : S_HOLD;
        end
      end
      S_HOLD: begin
        if (!rsp_wfull) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (HREADY) state_d = S_DATA;
      end
      S_DATA: begin
        if (HREADY) begin
          if (HRESP) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (!write_q) begin
            rdata_d = HRDATA;
            state_d = S_PUSH;
          end else if (cnt_q != '0) begin
            cnt_d   = cnt_q - C_ONE;
            addr_d  = addr_q + step;
            state_d = S_ADDR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_PUSH: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - C_ONE;
          addr_d  = addr_q + step;
          state_d = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= 2'd0;
      cnt_q   <= '0;
      rinc_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      rinc_q  <= rinc_d;
      err_q   <= err_d;
    end
  end

  assign cmd_rinc  = rinc_q;
  assign rsp_winc  = (state_q == S_PUSH);
  assign rsp_wdata = rdata_q;
  assign HADDR     = addr_q;
  assign HWRITE    = write_q;
  assign HTRANS    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign HSIZE     = {1'b0, size_q};
  assign HBURST    = 3'b000;
  assign HWDATA    = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule
